mtip_reg_lite: RTL
==================

# mtip_reg_lite

Parametrised, single-clock register, statistics and link-supervision block for NUM_CH MoreThanIP FC channels. It succeeds the stubbed register path of the single-channel MTIP wrapper. It provides:
- per-channel command/config registers (scrb_ena, ena_det, irq_en);
- eight saturating clear-on-read event counters per channel;
- a debounced link-state FSM with sticky link-down flag and interrupt;
- a busy/valid host handshake on the shared reg_* bus.

All inputs are already synchronous to clk; upstream CDC is done by vi_sync_level.

## Interface
Parameters:
- NUM_CH, 4: channel count, 1..16
- CNT_W, 32: event counter width, 8..32; read data is zero-extended
- UP_QUAL, 8: consecutive good cycles required to declare link up, ≥1
- DOWN_HOLD, 16: cycles a dropped link may stay in HOLD before it is declared down, ≥1

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; synchronous, active-low (already decided)
- evt  in  NUM_CH*8  single-cycle event pulses; per channel c, bits [8c+7:8c] = {tx_uflow_err, tx_crc_err, tx_frm_trmit, dec_error, rx_frm_rcv, rx_length_err, rx_frm_discard, rx_crc_err}
- sync_acqurd  in  NUM_CH  per-channel synchronisation status
- node_on_line  in  NUM_CH  per-channel online status
- reg_rd  in  1  read strobe, level
- reg_wr  in  1  write strobe, level
- reg_addr  in  [9:2]  word address; [9:6] = channel, [5:2] = offset
- reg_data_in  in  32  write data
- reg_data_out  out  32  read data
- reg_busy  out  1  access in progress
- scrb_ena  out  NUM_CH  per-channel scrambler enable
- ena_det  out  NUM_CH  per-channel comma-detect enable
- link_up  out  NUM_CH  debounced link state
- irq  out  1  OR over channels of (link_down_sticky & irq_en)

## Operation
Register map per channel (offset):
- 0x0 CMD_CFG: R/W. bit0 scrb_ena, bit10 ena_det, bit31 irq_en; other bits read 0.
- 0x1 STATUS:
  - bit0 link_up (RO)
  - bit1 sync_acqurd (RO, live)
  - bit2 node_on_line (RO, live)
  - bits[5:4] FSM state (RO): DOWN=0, UP=1, HOLD=2
  - bit8 link_down_sticky (W1C)
- 0x8..0xF CNT[0..7]: counter for evt bit (offset−8); clear-on-read; writes ignored.
- Other offsets read 0.
- Channel index ≥ NUM_CH: reads return 0 with no side effect; writes are ignored.

Counters:
- +1 per evt pulse; saturate at 2^CNT_W−1.
- When a clear-on-read and an event coincide on the same edge, the counter becomes 1; the event is not lost.

Link FSM, per channel, good = sync_acqurd & node_on_line:
- DOWN: qual counter increments while good and resets to 0 when not good. Go to UP on the cycle the count reaches UP_QUAL.
- UP: on !good, go to HOLD and load the hold counter.
- HOLD: good → UP, with no sticky set. Hold counter expires after DOWN_HOLD consecutive !good cycles → DOWN, and link_down_sticky sets.
- link_up = 1 in UP and HOLD.
- If sticky set (hardware) and a W1C clear coincide, set wins.

Host FSM (states IDLE, ACC, RESP, WAIT):
- IDLE: on reg_rd or reg_wr, latch address and data, go to ACC. If both strobes are high, the read wins and the write is dropped.
- ACC: reg_busy = 1. A write commits at the end of ACC. A read registers its data, and any counter clear happens at the end of ACC.
- RESP: reg_busy = 0 and reg_data_out holds the read value. Go to WAIT.
- WAIT: return to IDLE once both strobes are low. This gives one access per strobe assertion.

## Timing
- Reset values (rst_n low at a clk edge):
  - reg_data_out = 0, reg_busy = 0, irq = 0, link_up = 0
  - scrb_ena = 0, ena_det = all 1s (CMD_CFG = 0x400)
  - all counters 0, all sticky flags 0, all FSMs in DOWN, host FSM in IDLE
- Reset asserted mid-access aborts the access: no write commit and no counter clear.
- Strobe sampled at edge T. reg_busy = 1 during T+1. reg_data_out is valid from T+2 and holds until the next read's RESP.
- CMD_CFG written at T: scrb_ena/ena_det/irq_en change after edge T+2, i.e. visible from cycle T+2.
- Counter update: 1 cycle after the evt pulse.
- link_up: rises UP_QUAL cycles after good first rises; falls DOWN_HOLD cycles after good falls.
- irq: registered; rises 1 cycle after the sticky flag sets.

## Test plan
- Reset, then read ch0 CMD_CFG → 0x00000400; reg_busy high exactly 1 cycle; STATUS → 0.
- Write ch2 CMD_CFG = 0x00000001 → scrb_ena = 4'b0100, ena_det = 4'b1011; readback = 0x00000001; write to channel 5 with NUM_CH = 4 is ignored and reads back 0.
- Pulse ch1 rx_crc_err 3 times, read CNT[0] → 3, re-read → 0. With CNT_W = 8, 300 pulses → 255. An event coincident with the clearing read → next read returns 1.
- ch3 good held high: link_up rises exactly 8 cycles later. Drop good for 10 cycles → stays UP, no sticky. Drop for 16 cycles → DOWN, sticky = 1, irq = 1 only if irq_en = 1. W1C 0x100 to STATUS → irq = 0.
- reg_rd and reg_wr asserted together → read performed, write dropped. Strobe held 5 cycles → only one access; CNT cleared only once.

Source files
------------

// File: rtl/mtip_reg_lite.sv
// mtip_reg_lite: per-channel config registers, saturating clear-on-read event
// counters, debounced link supervision and a busy/valid host register port.
module mtip_reg_lite #(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 32,
   parameter int UP_QUAL   = 8,
   parameter int DOWN_HOLD = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH*8-1:0] evt,
   input  logic [NUM_CH-1:0]   sync_acqurd,
   input  logic [NUM_CH-1:0]   node_on_line,
   input  logic                reg_rd,
   input  logic                reg_wr,
   input  logic [9:2]          reg_addr,
   input  logic [31:0]         reg_data_in,
   output logic [31:0]         reg_data_out,
   output logic                reg_busy,
   output logic [NUM_CH-1:0]   scrb_ena,
   output logic [NUM_CH-1:0]   ena_det,
   output logic [NUM_CH-1:0]   link_up,
   output logic                irq,
   output logic [1:0]          host_state
);

   localparam int QW = $clog2(UP_QUAL + 1);
   localparam int HW = $clog2(DOWN_HOLD + 1);

   typedef enum logic [1:0] {
      H_IDLE = 2'd0,
      H_ACC  = 2'd1,
      H_RESP = 2'd2,
      H_WAIT = 2'd3
   } host_t;

   typedef enum logic [1:0] {
      L_DOWN = 2'd0,
      L_UP   = 2'd1,
      L_HOLD = 2'd2
   } link_t;

   host_t             h_state, h_next;
   logic              accept;
   logic [3:0]        lat_ch, lat_off;
   logic              lat_rd;
   logic [31:0]       lat_data;
   logic              acc_rd, acc_wr;
   logic [31:0]       rd_word;
   logic [NUM_CH-1:0] sticky, irq_en;
   logic [1:0]        lst [NUM_CH];
   logic [7:0][CNT_W-1:0] cnt_all [NUM_CH];
   logic              unused_data;

   // Host handshake: a rising reg_rd/reg_wr level in IDLE starts exactly one
   // access; reg_busy is high for the single ACC cycle, reg_data_out is valid
   // once busy drops and holds until the next read, and the strobes must both
   // return low before another access is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_state      <= H_IDLE;
         lat_ch       <= '0;
         lat_off      <= '0;
         lat_rd       <= 1'b0;
         lat_data     <= '0;
         reg_data_out <= '0;
         irq          <= 1'b0;
      end else begin
         h_state <= h_next;
         if (accept) begin
            lat_ch   <= reg_addr[9:6];
            lat_off  <= reg_addr[5:2];
            lat_rd   <= reg_rd;
            lat_data <= reg_data_in;
         end
         if (acc_rd) reg_data_out <= rd_word;
         irq <= |(sticky & irq_en);
      end
   end

   always_comb begin
      h_next = h_state;
      accept = 1'b0;
      case (h_state)
         H_IDLE: if (reg_rd || reg_wr) begin
            accept = 1'b1;
            h_next = H_ACC;
         end
         H_ACC:  h_next = H_RESP;
         H_RESP: h_next = H_WAIT;
         H_WAIT: if (!reg_rd && !reg_wr) h_next = H_IDLE;
         default: h_next = H_IDLE;
      endcase
   end

   assign reg_busy    = (h_state == H_ACC);
   assign host_state  = h_state;
   assign acc_rd      = (h_state == H_ACC) && lat_rd;
   assign acc_wr      = (h_state == H_ACC) && !lat_rd;
   assign unused_data = ^{lat_data[30:11], lat_data[9], lat_data[7:1]};

   // Unimplemented channels never match, so they read 0.
   always_comb begin
      rd_word = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (int'(lat_ch) == c) begin
            case (lat_off)
               4'h0: rd_word = {irq_en[c], 20'd0, ena_det[c], 9'd0, scrb_ena[c]};
               4'h1: rd_word = {23'd0, sticky[c], 2'd0, lst[c], 1'b0,
                                node_on_line[c], sync_acqurd[c], link_up[c]};
               4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF:
                  rd_word = 32'(cnt_all[c][lat_off[2:0]]);
               default: rd_word = '0;
            endcase
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic                  sel, good, wr_cfg, wr_stat;
      logic                  scrb_r, det_r, irq_en_r, sticky_r, sticky_set;
      logic [7:0]            clr;
      logic [7:0][CNT_W-1:0] cnt;
      link_t                 ls, ls_next;
      logic [QW-1:0]         qual, qual_next;
      logic [HW-1:0]         hold, hold_next;

      assign sel     = (int'(lat_ch) == c);
      assign good    = sync_acqurd[c] & node_on_line[c];
      assign wr_cfg  = acc_wr && sel && (lat_off == 4'h0);
      assign wr_stat = acc_wr && sel && (lat_off == 4'h1);
      assign clr     = (acc_rd && sel && lat_off[3]) ? (8'd1 << lat_off[2:0]) : 8'd0;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            scrb_r   <= 1'b0;
            det_r    <= 1'b1;
            irq_en_r <= 1'b0;
         end else if (wr_cfg) begin
            scrb_r   <= lat_data[0];
            det_r    <= lat_data[10];
            irq_en_r <= lat_data[31];
         end
      end

      // A clear coinciding with an event restarts the count at 1.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt <= '0;
         end else begin
            for (int k = 0; k < 8; k++) begin
               if (clr[k])
                  cnt[k] <= CNT_W'(evt[8*c+k]);
               else if (evt[8*c+k] && (cnt[k] != {CNT_W{1'b1}}))
                  cnt[k] <= cnt[k] + CNT_W'(1);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            ls       <= L_DOWN;
            qual     <= '0;
            hold     <= '0;
            sticky_r <= 1'b0;
         end else begin
            ls   <= ls_next;
            qual <= qual_next;
            hold <= hold_next;
            if (sticky_set)
               sticky_r <= 1'b1;
            else if (wr_stat && lat_data[8])
               sticky_r <= 1'b0;
         end
      end

      // hold counts the !good cycles already seen, including the UP exit cycle.
      always_comb begin
         ls_next    = ls;
         qual_next  = qual;
         hold_next  = hold;
         sticky_set = 1'b0;
         case (ls)
            L_DOWN: begin
               if (!good) begin
                  qual_next = '0;
               end else if (int'(qual) == UP_QUAL - 1) begin
                  qual_next = '0;
                  ls_next   = L_UP;
               end else begin
                  qual_next = qual + QW'(1);
               end
            end
            L_UP: begin
               if (!good) begin
                  if (DOWN_HOLD == 1) begin
                     ls_next    = L_DOWN;
                     sticky_set = 1'b1;
                  end else begin
                     ls_next   = L_HOLD;
                     hold_next = HW'(1);
                  end
               end
            end
            L_HOLD: begin
               if (good) begin
                  ls_next = L_UP;
               end else if (int'(hold) == DOWN_HOLD - 1) begin
                  ls_next    = L_DOWN;
                  sticky_set = 1'b1;
               end else begin
                  hold_next = hold + HW'(1);
               end
            end
            default: ls_next = L_DOWN;
         endcase
      end

      assign scrb_ena[c] = scrb_r;
      assign ena_det[c]  = det_r;
      assign irq_en[c]   = irq_en_r;
      assign sticky[c]   = sticky_r;
      assign link_up[c]  = (ls != L_DOWN);
      assign lst[c]      = ls;
      assign cnt_all[c]  = cnt;
   end

endmodule
